dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU on port a, loader/DMA on port b) with lock support and a registered memory interface.
// Optional round-robin IDLE contention policy is enabled by defining ARB_RR_EN; the default build always favours port a.
module dmem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int LOCK_TMO = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              wr,
  output logic              reade,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  localparam logic [4:0] TMO_LAST = 5'(LOCK_TMO - 1);

  state_t            r_state;
  state_t            w_nxt_state;
  logic [4:0]        r_idle_cnt;
  logic [4:0]        w_nxt_cnt;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_own_req;
  logic              w_own_gnt;
  logic              w_own_lock;

  logic              r_wr;
  logic              r_reade;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_own_b;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

`ifdef ARB_RR_EN
  logic              r_last_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (w_gnt) begin
      r_last_b <= w_b_gnt;
    end
  end
`endif

  // Grant is combinational so a requester can move on in the same cycle it is accepted.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (a_req && b_req) begin
`ifdef ARB_RR_EN
            if (r_last_b) w_a_gnt = 1'b1;
            else          w_b_gnt = 1'b1;
`else
            w_a_gnt = 1'b1;
`endif
          end else begin
            w_a_gnt = a_req;
            w_b_gnt = b_req;
          end
        end
        ST_LOCK_A: w_a_gnt = a_req;
        ST_LOCK_B: w_b_gnt = b_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_own_req  = 1'b0;
    w_own_gnt  = 1'b0;
    w_own_lock = 1'b0;
    if (r_state == ST_LOCK_A) begin
      w_own_req  = a_req;
      w_own_gnt  = w_a_gnt;
      w_own_lock = a_lock;
    end else if (r_state == ST_LOCK_B) begin
      w_own_req  = b_req;
      w_own_gnt  = w_b_gnt;
      w_own_lock = b_lock;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_idle_cnt;
    case (r_state)
      ST_IDLE: begin
        w_nxt_cnt = 5'd0;
        if (w_a_gnt && a_lock)      w_nxt_state = ST_LOCK_A;
        else if (w_b_gnt && b_lock) w_nxt_state = ST_LOCK_B;
      end
      ST_LOCK_A, ST_LOCK_B: begin
        if (w_own_req) begin
          w_nxt_cnt = 5'd0;
          if (w_own_gnt && !w_own_lock) w_nxt_state = ST_IDLE;
        end else if (r_idle_cnt == TMO_LAST) begin
          // Owner went quiet too long; release so the other port cannot starve.
          w_nxt_cnt   = 5'd0;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_cnt = r_idle_cnt + 5'd1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= 5'd0;
    end else begin
      r_state    <= w_nxt_state;
      r_idle_cnt <= w_nxt_cnt;
    end
  end

  assign w_gnt   = w_a_gnt | w_b_gnt;
  assign w_we    = w_b_gnt ? b_we    : a_we;
  assign w_addr  = w_b_gnt ? b_addr  : a_addr;
  assign w_wdata = w_b_gnt ? b_wdata : a_wdata;

  // Stage 1 drives the memory; stage 2 returns read data to whichever port issued it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr       <= 1'b0;
      r_reade    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_own_b <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_wr       <= w_gnt & w_we;
      r_reade    <= w_gnt & ~w_we;
      r_addr     <= w_gnt ? w_addr  : '0;
      r_wdata    <= w_gnt ? w_wdata : '0;
      r_rd_own_b <= w_b_gnt;
      r_a_rvalid <= r_reade & ~r_rd_own_b;
      r_b_rvalid <= r_reade &  r_rd_own_b;
      if (r_reade && !r_rd_own_b) r_a_rdata <= rd_data;
      if (r_reade &&  r_rd_own_b) r_b_rdata <= rd_data;
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign wr       = r_wr;
  assign reade    = r_reade;
  assign addr     = r_addr;
  assign wr_data  = r_wdata;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of per-cycle vectors plus hand-written lock, timeout and reset sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [8:0]  a_addr, b_addr, addr;
  logic [31:0] a_wdata, b_wdata, wr_data, rd_data, a_rdata, b_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, wr, reade;

  int n_vec = 0;
  int n_err = 0;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .LOCK_TMO(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .wr(wr), .reade(reade), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a_req, a_we, a_lock;
    logic [8:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req, b_we, b_lock;
    logic [8:0]  b_addr;
    logic [31:0] b_wdata;
    logic [31:0] rd_data;
    logic        e_agnt, e_bgnt, e_wr, e_rd;
    logic [8:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_arv, e_brv;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    input logic ar, aw, al, input logic [8:0] aa, input logic [31:0] ad,
    input logic br, bw, bl, input logic [8:0] ba, input logic [31:0] bd,
    input logic [31:0] rd,
    input logic eag, ebg, ewr, erd, input logic [8:0] ea, input logic [31:0] ewd,
    input logic earv, ebrv, input logic [31:0] erdat);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
    v.rd_data = rd;
    v.e_agnt = eag; v.e_bgnt = ebg; v.e_wr = ewr; v.e_rd = erd; v.e_addr = ea; v.e_wd = ewd;
    v.e_arv = earv; v.e_brv = ebrv; v.e_rdat = erdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic apply(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_lock = v.a_lock; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wdata;
    rd_data = v.rd_data;
  endtask

  initial begin
    int n;
    // Contention rows 8..11: a and b both write; the grant pattern depends on the policy.
    tbl[0]  = mk(1,1,0,9'd5,32'hDEADBEEF, 0,0,0,9'd0,0, 0,           1,0,0,0,9'd0,0, 0,0,0);
    tbl[1]  = mk(1,0,0,9'd5,0,            0,0,0,9'd0,0, 0,           1,0,1,0,9'd5,32'hDEADBEEF, 0,0,0);
    tbl[2]  = mk(0,0,0,9'd0,0,            0,0,0,9'd0,0, 32'hDEADBEEF,0,0,0,1,9'd5,0, 0,0,0);
    tbl[3]  = mk(0,0,0,9'd0,0,            0,0,0,9'd0,0, 0,           0,0,0,0,9'd0,0, 1,0,32'hDEADBEEF);
    tbl[4]  = mk(0,0,0,9'd0,0,            1,1,0,9'd9,32'h11111111, 0, 0,1,0,0,9'd0,0, 0,0,0);
    tbl[5]  = mk(0,0,0,9'd0,0,            1,0,0,9'd3,0, 0,           0,1,1,0,9'd9,32'h11111111, 0,0,0);
    tbl[6]  = mk(0,0,0,9'd0,0,            0,0,0,9'd0,0, 32'hCAFEF00D,0,0,0,1,9'd3,0, 0,0,0);
    tbl[7]  = mk(0,0,0,9'd0,0,            0,0,0,9'd0,0, 0,           0,0,0,0,9'd0,0, 0,1,32'hCAFEF00D);
    tbl[8]  = mk(1,1,0,9'd1,32'hAAAA0001, 1,1,0,9'd2,32'hBBBB0002, 0, 1,0,0,0,9'd0,0, 0,0,0);
    tbl[9]  = mk(1,1,0,9'd1,32'hAAAA0001, 1,1,0,9'd2,32'hBBBB0002, 0, !RR,RR,1,0,9'd1,32'hAAAA0001, 0,0,0);
    tbl[10] = mk(1,1,0,9'd1,32'hAAAA0001, 1,1,0,9'd2,32'hBBBB0002, 0, 1,0,1,0,
                 RR ? 9'd2 : 9'd1, RR ? 32'hBBBB0002 : 32'hAAAA0001, 0,0,0);
    tbl[11] = mk(1,1,0,9'd1,32'hAAAA0001, 1,1,0,9'd2,32'hBBBB0002, 0, !RR,RR,1,0,9'd1,32'hAAAA0001, 0,0,0);
    tbl[12] = mk(0,0,0,9'd0,0,            0,0,0,9'd0,0, 0,           0,0,1,0,
                 RR ? 9'd2 : 9'd1, RR ? 32'hBBBB0002 : 32'hAAAA0001, 0,0,0);
    tbl[13] = mk(0,0,0,9'd0,0,            0,0,0,9'd0,0, 0,           0,0,0,0,9'd0,0, 0,0,0);

    reset = 1'b1; rd_data = '0;
    quiet();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset wr", {31'd0, wr}, 0);
    chk("reset reade", {31'd0, reade}, 0);
    chk("reset addr", {23'd0, addr}, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("reset rdata", a_rdata | b_rdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d a_gnt", i), {31'd0, a_gnt}, {31'd0, tbl[i].e_agnt});
      chk($sformatf("row%0d b_gnt", i), {31'd0, b_gnt}, {31'd0, tbl[i].e_bgnt});
      chk($sformatf("row%0d wr", i), {31'd0, wr}, {31'd0, tbl[i].e_wr});
      chk($sformatf("row%0d reade", i), {31'd0, reade}, {31'd0, tbl[i].e_rd});
      if (tbl[i].e_wr || tbl[i].e_rd)
        chk($sformatf("row%0d addr", i), {23'd0, addr}, {23'd0, tbl[i].e_addr});
      if (tbl[i].e_wr)
        chk($sformatf("row%0d wr_data", i), wr_data, tbl[i].e_wd);
      chk($sformatf("row%0d a_rvalid", i), {31'd0, a_rvalid}, {31'd0, tbl[i].e_arv});
      chk($sformatf("row%0d b_rvalid", i), {31'd0, b_rvalid}, {31'd0, tbl[i].e_brv});
      if (tbl[i].e_arv) chk($sformatf("row%0d a_rdata", i), a_rdata, tbl[i].e_rdat);
      if (tbl[i].e_brv) chk($sformatf("row%0d b_rdata", i), b_rdata, tbl[i].e_rdat);
    end

    // b takes a lock while a waits; a is shut out until b's unlocking access.
    @(negedge clk); quiet();
    b_req = 1; b_we = 1; b_lock = 1; b_addr = 9'd20; b_wdata = 32'h0000B001;
    #1 chk("lock b first gnt", {31'd0, b_gnt}, 1);
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 9'd30; a_wdata = 32'h0000A030;
    #1 chk("lock a blocked 1", {30'd0, a_gnt, b_gnt}, 32'b01);
    @(negedge clk); b_req = 0;
    #1 chk("lock a blocked idle", {30'd0, a_gnt, b_gnt}, 32'b00);
    @(negedge clk); b_req = 1;
    #1 chk("lock a blocked 2", {30'd0, a_gnt, b_gnt}, 32'b01);
    @(negedge clk); b_lock = 0;
    #1 chk("lock unlock access", {30'd0, a_gnt, b_gnt}, 32'b01);
    @(negedge clk); b_req = 0;
    #1 chk("lock a released", {30'd0, a_gnt, b_gnt}, 32'b10);
    @(negedge clk); quiet();
    #1 chk("lock a write addr", {22'd0, wr, addr}, {22'd0, 1'b1, 9'd30});

    // b locks then goes silent; a must get in only after the timeout.
    @(negedge clk);
    b_req = 1; b_we = 1; b_lock = 1; b_addr = 9'd40;
    #1 chk("tmo b gnt", {31'd0, b_gnt}, 1);
    @(negedge clk);
    b_req = 0; b_lock = 0; a_req = 1; a_we = 1; a_addr = 9'd41;
    n = 1;
    #1;
    while (!a_gnt && n <= 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("tmo first a_gnt cycle", n, 17);
    @(negedge clk); quiet();

    // Reset one cycle after a read grant: the read must never return.
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 9'd7; rd_data = 32'h12345678;
    #1 chk("rst read gnt", {31'd0, a_gnt}, 1);
    @(negedge clk);
    reset = 1; a_we = 1; a_addr = 9'd8; a_wdata = 32'h00000088;
    #1 chk("rst gnt masked", {30'd0, a_gnt, b_gnt}, 0);
    chk("rst read strobe", {31'd0, reade}, 1);
    @(negedge clk);
    reset = 0;
    #1 chk("rst outputs clear", {28'd0, wr, reade, a_rvalid, b_rvalid}, 0);
    chk("rst addr clear", {23'd0, addr}, 0);
    chk("rst a_rdata clear", a_rdata, 0);
    chk("rst fresh gnt", {31'd0, a_gnt}, 1);
    @(negedge clk); quiet();
    #1 chk("rst no rvalid 1", {31'd0, a_rvalid}, 0);
    chk("rst fresh write", {22'd0, wr, addr}, {22'd0, 1'b1, 9'd8});
    @(negedge clk);
    #1 chk("rst no rvalid 2", {31'd0, a_rvalid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
